// File: rtl/adf4159_hop_ctrl.sv
// Frequency-hop sequencer for an ADF4159 register programmer: steps through a 16-entry
// hop table, hands each INT/FRAC word to the programmer and dwells between hops.
module adf4159_hop_ctrl #(
  parameter int unsigned DWELL_W = 24,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tbl_we,
  input  logic [3:0]         tbl_addr,
  input  logic [11:0]        tbl_ints,
  input  logic [24:0]        tbl_fracs,
  input  logic [DWELL_W-1:0] tbl_dwell,
  input  logic [3:0]         num_hops,
  input  logic               loop_en,
  input  logic               start,
  input  logic               stop,
  input  logic               pll_busy,
  output logic               pll_load,
  output logic [11:0]        pll_ints,
  output logic [24:0]        pll_fracs,
  output logic [3:0]         hop_idx,
  output logic               running,
  output logic               hop_strobe,
  output logic               seq_done,
  output logic               err
);

  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {StIdle, StIssue, StWaitBusy, StWaitDone, StDwell} state_e;

  state_e state_q, state_d;

  logic [11:0]        tbl_ints_q  [16];
  logic [24:0]        tbl_fracs_q [16];
  logic [DWELL_W-1:0] tbl_dwell_q [16];

  logic [11:0]        ints_q, ints_d;
  logic [24:0]        fracs_q, fracs_d;
  logic [3:0]         hop_idx_q, hop_idx_d;
  logic [3:0]         last_q, last_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [TmoW-1:0]    tmo_q, tmo_d;
  logic               load_q, load_d;
  logic               strobe_q, strobe_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               stop_pend_q, stop_pend_d;
  logic               tmo_hit;
  logic               last_hop;

  // Table is deliberately not reset; a same-cycle write is seen by ISSUE only next time.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      tbl_ints_q[tbl_addr]  <= tbl_ints;
      tbl_fracs_q[tbl_addr] <= tbl_fracs;
      tbl_dwell_q[tbl_addr] <= tbl_dwell;
    end
  end

  assign tmo_hit  = (tmo_q == TmoW'(TIMEOUT - 1));
  assign last_hop = (hop_idx_q >= last_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ints_q      <= '0;
      fracs_q     <= '0;
      hop_idx_q   <= '0;
      last_q      <= '0;
      dwell_q     <= '0;
      tmo_q       <= '0;
      load_q      <= 1'b0;
      strobe_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ints_q      <= ints_d;
      fracs_q     <= fracs_d;
      hop_idx_q   <= hop_idx_d;
      last_q      <= last_d;
      dwell_q     <= dwell_d;
      tmo_q       <= tmo_d;
      load_q      <= load_d;
      strobe_q    <= strobe_d;
      done_q      <= done_d;
      err_q       <= err_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (start && !stop) state_d = StIssue;
      StIssue:    state_d = StWaitBusy;
      StWaitBusy: begin
        if (pll_busy)     state_d = StWaitDone;
        else if (tmo_hit) state_d = StIdle;
      end
      // A pending stop still lets the transfer finish before dropping to idle.
      StWaitDone: if (!pll_busy) state_d = (stop_pend_q || stop) ? StIdle : StDwell;
      StDwell: begin
        if (stop)                state_d = StIdle;
        else if (dwell_q == '0)  state_d = (!last_hop || loop_en) ? StIssue : StIdle;
      end
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    ints_d      = ints_q;
    fracs_d     = fracs_q;
    hop_idx_d   = hop_idx_q;
    last_d      = last_q;
    dwell_d     = dwell_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    stop_pend_d = stop_pend_q;
    load_d      = 1'b0;
    strobe_d    = 1'b0;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          hop_idx_d = '0;
          last_d    = num_hops;
          err_d     = 1'b0;
        end
      end
      StIssue: begin
        ints_d  = tbl_ints_q[hop_idx_q];
        fracs_d = tbl_fracs_q[hop_idx_q];
        load_d  = 1'b1;
        tmo_d   = '0;
      end
      StWaitBusy: begin
        if (!pll_busy) begin
          if (tmo_hit) err_d = 1'b1;
          else         tmo_d = tmo_q + TmoW'(1);
        end
      end
      StWaitDone: begin
        if (!pll_busy) begin
          strobe_d = 1'b1;
          dwell_d  = tbl_dwell_q[hop_idx_q];
        end
      end
      StDwell: begin
        if (!stop) begin
          if (dwell_q != '0)  dwell_d   = dwell_q - DWELL_W'(1);
          else if (!last_hop) hop_idx_d = hop_idx_q + 4'd1;
          else if (loop_en)   hop_idx_d = '0;
          else                done_d    = 1'b1;
        end
      end
      default: ;
    endcase
    if (stop && (state_q inside {StIssue, StWaitBusy, StWaitDone})) stop_pend_d = 1'b1;
    if (state_d == StIdle) stop_pend_d = 1'b0;
  end

  assign pll_load   = load_q;
  assign pll_ints   = ints_q;
  assign pll_fracs  = fracs_q;
  assign hop_idx    = hop_idx_q;
  assign running    = (state_q != StIdle);
  assign hop_strobe = strobe_q;
  assign seq_done   = done_q;
  assign err        = err_q;

endmodule

// File: doc/adf4159_hop_ctrl.md
ADF4159_HOP_CTRL -- requirements
Module: adf4159_hop_ctrl

Interface
REQ-001 Parameter DWELL_W, default 24, width of per-hop dwell count.
REQ-002 Parameter TIMEOUT, default 16, max cycles from pll_load to pll_busy rising.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 tbl_we  in  1  hop-table write enable.
REQ-006 tbl_addr  in  4  hop-table write address, 16 entries.
REQ-007 tbl_ints  in  12  integer word written to entry.
REQ-008 tbl_fracs  in  25  fractional word written to entry.
REQ-009 tbl_dwell  in  DWELL_W  dwell count written to entry.
REQ-010 num_hops  in  4  index of last hop; sequence length = num_hops+1.
REQ-011 loop_en  in  1  1 = restart at entry 0 after last hop.
REQ-012 start  in  1  one-cycle start request.
REQ-013 stop  in  1  one-cycle stop request.
REQ-014 pll_busy  in  1  busy from the ADF4159 register programmer.
REQ-015 pll_load  out  1  one-cycle load pulse to the programmer.
REQ-016 pll_ints  out  12  integer word to the programmer, registered.
REQ-017 pll_fracs  out  25  fractional word to the programmer, registered.
REQ-018 hop_idx  out  4  index of current hop.
REQ-019 running  out  1  high in every state except IDLE.
REQ-020 hop_strobe  out  1  one-cycle pulse when programming of a hop completes.
REQ-021 seq_done  out  1  one-cycle pulse when a non-looping sequence ends.
REQ-022 err  out  1  sticky timeout flag.

Function
REQ-023 Table: 16 x (12+25+DWELL_W) registers; write on clk when tbl_we, any state; a write and an ISSUE read of the same entry in the same cycle shall return the old value.
REQ-024 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DWELL.
REQ-025 IDLE: start=1 and stop=0 -> hop_idx=0, latch num_hops, clear err, go ISSUE; start while not IDLE ignored.
REQ-026 ISSUE (one cycle): pll_ints/pll_fracs <= table[hop_idx]; pll_load=1 on the following cycle for exactly one cycle, coincident with valid pll_ints/pll_fracs; go WAIT_BUSY.
REQ-027 pll_ints/pll_fracs shall hold their value until the next ISSUE.
REQ-028 WAIT_BUSY: pll_busy=1 -> WAIT_DONE; no pll_busy within TIMEOUT cycles after pll_load -> err=1, go IDLE, no seq_done.
REQ-029 WAIT_DONE: pll_busy=0 -> hop_strobe=1 one cycle, dwell counter <= table[hop_idx] dwell, go DWELL.
REQ-030 DWELL lasts exactly dwell+1 cycles (dwell=0 -> one cycle).
REQ-031 DWELL end, hop_idx<latched num_hops: hop_idx+1, go ISSUE.
REQ-032 DWELL end, hop_idx=latched num_hops: loop_en=1 -> hop_idx=0, go ISSUE; loop_en=0 -> seq_done=1 one cycle, go IDLE; loop_en sampled at that cycle.
REQ-033 stop in DWELL: go IDLE next cycle, no seq_done.
REQ-034 stop in ISSUE/WAIT_BUSY/WAIT_DONE: set stop_pending; when WAIT_DONE exits, still pulse hop_strobe, then go IDLE instead of DWELL; a programmer transfer is never cut short.
REQ-035 start and stop in same cycle in IDLE: stop wins, remain IDLE.
REQ-036 stop_pending cleared on entry to IDLE.
REQ-037 hop_idx retains last value in IDLE.

Reset
REQ-038 rst=1: state IDLE; pll_load, running, hop_strobe, seq_done, err, stop_pending = 0; hop_idx, pll_ints, pll_fracs, counters = 0; table contents not reset.
REQ-039 rst mid-operation takes effect on the next edge; pll_load shall not pulse in the cycle after rst deasserts.

Verification
REQ-040 Write entries 0..2 (ints 100/200/300, fracs 0x1/0x2/0x3, dwell 5), num_hops=2, loop_en=0, start; programmer model busy 3..40 cycles after load -> three pll_load pulses with 100/200/300, three hop_strobe, DWELL 6 cycles each, one seq_done, running falls.
REQ-041 Same table, loop_en=1 -> hop_idx sequence 0,1,2,0,1; stop asserted in DWELL of second hop 1 -> IDLE next cycle, no seq_done.
REQ-042 Programmer model never asserts busy -> err=1 exactly TIMEOUT cycles after pll_load, IDLE, no hop_strobe; next start clears err.
REQ-043 stop in WAIT_BUSY -> hop_strobe after busy falls, then IDLE, no further pll_load.
REQ-044 dwell=0, num_hops=0 -> single pll_load, hop_strobe, one DWELL cycle, seq_done.
REQ-045 start+stop same cycle in IDLE -> no pll_load; rst asserted in WAIT_DONE -> all outputs 0 next cycle.
